// File: rtl/ex_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU commands, shift types,
// forwarding selects and the multiplier FSM state.
package ex_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_val2_gen.sv
// Operand-2 generator: rotated imm8, shifted register, or zero-extended memory offset.
// Purely combinational.
module ex_val2_gen
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] val_rm,
    input  logic [11:0]       shift_operand,
    input  logic              immd,
    input  logic              mem_op,
    output logic [DATA_W-1:0] val2
);

    logic [2*DATA_W-1:0] rot_src;
    logic [DATA_W-1:0]   imm_ext;
    logic [4:0]          shift_imm;
    int unsigned         rot_amt;

    always_comb begin
        val2      = '0;
        rot_src   = '0;
        rot_amt   = 0;
        imm_ext   = DATA_W'(shift_operand[7:0]);
        shift_imm = shift_operand[11:7];
        if (mem_op) begin
            val2 = DATA_W'(shift_operand);
        end else if (immd) begin
            rot_amt = 32'({shift_operand[11:8], 1'b0}) % DATA_W;
            rot_src = {imm_ext, imm_ext} >> rot_amt;
            val2    = rot_src[DATA_W-1:0];
        end else begin
            case (shift_operand[6:5])
                SH_LSL: val2 = val_rm << shift_imm;
                SH_LSR: val2 = val_rm >> shift_imm;
                SH_ASR: val2 = $signed(val_rm) >>> shift_imm;
                default: begin
                    // rotating a doubled copy keeps the wrap-around in one shift
                    rot_amt = 32'(shift_imm) % DATA_W;
                    rot_src = {val_rm, val_rm} >> rot_amt;
                    val2    = rot_src[DATA_W-1:0];
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage with EX/MEM register and an iterative multiplier that stalls upstream.
// Single-cycle ops register next cycle; MUL takes N_ITER+1 cycles.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int DATA_W             = 32,
    parameter int ADDR_W             = 32,
    parameter int REG_ADDR_W         = 4,
    parameter int MUL_BITS_PER_CYCLE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze_in,
    input  logic                  flush_in,
    input  logic                  valid_in,
    input  logic [ADDR_W-1:0]     pc_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  status_w_en_in,
    input  logic                  branch_taken_in,
    input  logic                  immd_in,
    input  logic [3:0]            exe_cmd_in,
    input  logic [DATA_W-1:0]     val_rn_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [23:0]           signed_immd_24_in,
    input  logic [11:0]           shift_operand_in,
    input  logic [3:0]            status_reg_in,
    input  logic [1:0]            fwd_sel_src1,
    input  logic [1:0]            fwd_sel_src2,
    input  logic [DATA_W-1:0]     mem_wb_value,
    input  logic [DATA_W-1:0]     wb_wb_value,
    output logic                  stall_out,
    output logic                  wb_en_hazard_out,
    output logic [REG_ADDR_W-1:0] dest_hazard_out,
    output logic                  status_w_en_out,
    output logic [3:0]            status_out,
    output logic                  branch_taken_out,
    output logic [ADDR_W-1:0]     branch_address_out,
    output logic                  valid_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic [DATA_W-1:0]     alu_res_out,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic [REG_ADDR_W-1:0] dest_out
);

    localparam int N_ITER = DATA_W / MUL_BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

    ex_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     mcand_q, mplier_q, acc_q, mul_rm_q;
    logic                  mul_wb_en_q, mul_mem_r_q, mul_mem_w_q;
    logic [REG_ADDR_W-1:0] mul_dest_q;

    logic [DATA_W-1:0] rn_fwd, rm_fwd, val2, alu_res, mul_sum, result, b_eff;
    logic [DATA_W:0]   sum;
    logic              cin, alu_c, alu_v;
    logic              is_mul, busy, mul_start, mul_step, mul_done, commit;

    always_comb begin
        case (fwd_sel_src1)
            FWD_MEM: rn_fwd = mem_wb_value;
            FWD_WB:  rn_fwd = wb_wb_value;
            default: rn_fwd = val_rn_in;
        endcase
        case (fwd_sel_src2)
            FWD_MEM: rm_fwd = mem_wb_value;
            FWD_WB:  rm_fwd = wb_wb_value;
            default: rm_fwd = val_rm_in;
        endcase
    end

    ex_val2_gen #(.DATA_W(DATA_W)) u_val2_gen (
        .val_rm        (rm_fwd),
        .shift_operand (shift_operand_in),
        .immd          (immd_in),
        .mem_op        (mem_r_en_in | mem_w_en_in),
        .val2          (val2)
    );

    // Subtraction is a + ~b + carry, so C comes out as "not borrow".
    always_comb begin
        alu_res = '0;
        alu_c   = status_reg_in[1];
        alu_v   = status_reg_in[0];
        b_eff   = (exe_cmd_in == CMD_SUB || exe_cmd_in == CMD_SBC) ? ~val2 : val2;
        cin     = (exe_cmd_in == CMD_SUB) |
                  ((exe_cmd_in == CMD_ADC || exe_cmd_in == CMD_SBC) & status_reg_in[1]);
        sum     = {1'b0, rn_fwd} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
        case (exe_cmd_in)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (rn_fwd[DATA_W-1] == b_eff[DATA_W-1]) &&
                          (sum[DATA_W-1] != rn_fwd[DATA_W-1]);
            end
            CMD_AND: alu_res = rn_fwd & val2;
            CMD_ORR: alu_res = rn_fwd | val2;
            CMD_EOR: alu_res = rn_fwd ^ val2;
            default: alu_res = '0;
        endcase
    end

    assign busy      = (state_q == ST_BUSY);
    assign is_mul    = (exe_cmd_in == CMD_MUL);
    assign mul_start = !busy && valid_in && is_mul && !flush_in && !freeze_in;
    assign mul_step  = busy && !flush_in && !freeze_in;
    assign mul_done  = mul_step && (cnt_q == LAST);
    assign commit    = !flush_in && !freeze_in && ((!busy && !is_mul) || mul_done);
    assign mul_sum   = acc_q + mcand_q * DATA_W'(mplier_q[MUL_BITS_PER_CYCLE-1:0]);
    assign result    = busy ? mul_sum : alu_res;

    assign status_out         = {result[DATA_W-1], ~|result,
                                 busy ? status_reg_in[1:0] : {alu_c, alu_v}};
    assign status_w_en_out    = status_w_en_in & valid_in & commit;
    assign branch_taken_out   = branch_taken_in & valid_in & commit;
    assign branch_address_out = pc_in + (ADDR_W'($signed(signed_immd_24_in)) << 2);
    assign wb_en_hazard_out   = wb_en_in;
    assign dest_hazard_out    = dest_in;

    always_comb begin
        state_d   = state_q;
        stall_out = 1'b0;
        if (flush_in) begin
            state_d = ST_IDLE;
        end else if (freeze_in) begin
            stall_out = 1'b1;
        end else if (mul_start) begin
            state_d   = ST_BUSY;
            stall_out = 1'b1;
        end else if (busy) begin
            stall_out = (cnt_q != LAST);
            if (cnt_q == LAST) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst)           cnt_q <= '0;
        else if (mul_start || mul_done) cnt_q <= '0;
        else if (mul_step) cnt_q <= cnt_q + CNT_W'(1);
    end

    // Shift-and-add: the multiplicand moves up as multiplier digits are consumed.
    always_ff @(posedge clk) begin
        if (mul_start) begin
            mcand_q     <= rn_fwd;
            mplier_q    <= rm_fwd;
            acc_q       <= '0;
            mul_rm_q    <= rm_fwd;
            mul_wb_en_q <= wb_en_in;
            mul_mem_r_q <= mem_r_en_in;
            mul_mem_w_q <= mem_w_en_in;
            mul_dest_q  <= dest_in;
        end else if (mul_step) begin
            acc_q    <= mul_sum;
            mcand_q  <= mcand_q << MUL_BITS_PER_CYCLE;
            mplier_q <= mplier_q >> MUL_BITS_PER_CYCLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_in || mul_start) begin
            valid_out    <= 1'b0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            alu_res_out  <= '0;
            val_rm_out   <= '0;
            dest_out     <= '0;
        end else if (mul_done) begin
            valid_out    <= 1'b1;
            wb_en_out    <= mul_wb_en_q;
            mem_r_en_out <= mul_mem_r_q;
            mem_w_en_out <= mul_mem_w_q;
            alu_res_out  <= mul_sum;
            val_rm_out   <= mul_rm_q;
            dest_out     <= mul_dest_q;
        end else if (!freeze_in && !busy) begin
            valid_out    <= valid_in;
            wb_en_out    <= wb_en_in & valid_in;
            mem_r_en_out <= mem_r_en_in & valid_in;
            mem_w_en_out <= mem_w_en_in & valid_in;
            alu_res_out  <= alu_res;
            val_rm_out   <= rm_fwd;
            dest_out     <= dest_in;
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Randomized bench for ex_stage_mc against an arithmetic reference model.
module tb_ex_stage_mc;

    logic        clk = 1'b0;
    logic        rst, freeze_in, flush_in, valid_in;
    logic [31:0] pc_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, status_w_en_in, branch_taken_in, immd_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] val_rn_in, val_rm_in;
    logic [3:0]  dest_in;
    logic [23:0] signed_immd_24_in;
    logic [11:0] shift_operand_in;
    logic [3:0]  status_reg_in;
    logic [1:0]  fwd_sel_src1, fwd_sel_src2;
    logic [31:0] mem_wb_value, wb_wb_value;
    logic        stall_out, wb_en_hazard_out, status_w_en_out, branch_taken_out;
    logic [3:0]  dest_hazard_out, status_out, dest_out;
    logic [31:0] branch_address_out, alu_res_out, val_rm_out;
    logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ex_stage_mc dut (
        .clk(clk), .rst(rst), .freeze_in(freeze_in), .flush_in(flush_in),
        .valid_in(valid_in), .pc_in(pc_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .status_w_en_in(status_w_en_in), .branch_taken_in(branch_taken_in),
        .immd_in(immd_in), .exe_cmd_in(exe_cmd_in), .val_rn_in(val_rn_in),
        .val_rm_in(val_rm_in), .dest_in(dest_in), .signed_immd_24_in(signed_immd_24_in),
        .shift_operand_in(shift_operand_in), .status_reg_in(status_reg_in),
        .fwd_sel_src1(fwd_sel_src1), .fwd_sel_src2(fwd_sel_src2),
        .mem_wb_value(mem_wb_value), .wb_wb_value(wb_wb_value),
        .stall_out(stall_out), .wb_en_hazard_out(wb_en_hazard_out),
        .dest_hazard_out(dest_hazard_out), .status_w_en_out(status_w_en_out),
        .status_out(status_out), .branch_taken_out(branch_taken_out),
        .branch_address_out(branch_address_out), .valid_out(valid_out),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .alu_res_out(alu_res_out), .val_rm_out(val_rm_out), .dest_out(dest_out)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int r);
        int k;
        k = r % 32;
        return (x >> k) | (x << (32 - k));
    endfunction

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rv,
                                          input logic [31:0] mv, input logic [31:0] wv);
        if (sel == 2'b01) return mv;
        if (sel == 2'b10) return wv;
        return rv;
    endfunction

    function automatic logic [31:0] m_op2(input logic immd, input logic memop,
                                          input logic [11:0] so, input logic [31:0] rm);
        int sh;
        sh = int'(so[11:7]);
        if (memop) return {20'd0, so};
        if (immd)  return m_rotr({24'd0, so[7:0]}, 2 * int'(so[11:8]));
        case (so[6:5])
            2'd0:    return rm << sh;
            2'd1:    return rm >> sh;
            2'd2:    return 32'($signed(rm) >>> sh);
            default: return m_rotr(rm, sh);
        endcase
    endfunction

    task automatic m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] nzcv, output logic [31:0] res, output logic [3:0] flags);
        longint sa, sb, ss, rs;
        logic [63:0] ua;
        logic c, v;
        int cin;
        sa = $signed(a);
        sb = $signed(b);
        c  = nzcv[1];
        v  = nzcv[0];
        res = 32'd0;
        case (cmd)
            4'd1:  res = b;
            4'd9:  res = ~b;
            4'd2, 4'd3: begin
                cin = (cmd == 4'd3) ? int'(c) : 0;
                ua  = {32'd0, a} + {32'd0, b} + 64'(cin);
                res = ua[31:0];
                c   = ua[32];
                ss  = sa + sb + longint'(cin);
                rs  = $signed(res);
                v   = (ss != rs);
            end
            4'd4, 4'd5: begin
                cin = (cmd == 4'd4) ? 0 : int'(!c);
                res = a - b - 32'(cin);
                c   = ({32'd0, a} >= {32'd0, b} + 64'(cin));
                ss  = sa - sb - longint'(cin);
                rs  = $signed(res);
                v   = (ss != rs);
            end
            4'd6:  res = a & b;
            4'd7:  res = a | b;
            4'd8:  res = a ^ b;
            4'd10: res = a * b;
            default: res = 32'd0;
        endcase
        flags = {res[31], res == 32'd0, c, v};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst = 1'b0; freeze_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0;
        pc_in = '0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        status_w_en_in = 1'b0; branch_taken_in = 1'b0; immd_in = 1'b0;
        exe_cmd_in = 4'd0; val_rn_in = '0; val_rm_in = '0; dest_in = '0;
        signed_immd_24_in = '0; shift_operand_in = '0; status_reg_in = '0;
        fwd_sel_src1 = 2'b00; fwd_sel_src2 = 2'b00; mem_wb_value = '0; wb_wb_value = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b exp 0000", {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out});
        end
        tests_run++;
        if ({alu_res_out, val_rm_out, dest_out} !== 68'd0) begin
            tests_failed++;
            $display("FAIL reset_data got %h %h %h exp 0", alu_res_out, val_rm_out, dest_out);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stall got %b exp 0", stall_out);
        end
    endtask

    task automatic test_add_basic();
        drive_idle();
        valid_in = 1'b1; exe_cmd_in = 4'b0010; val_rn_in = 32'd5; val_rm_in = 32'd7;
        wb_en_in = 1'b1; dest_in = 4'd3;
        #1;
        tests_run++;
        if (stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_stall got %b exp 0", stall_out);
        end
        tick();
        tests_run++;
        if (alu_res_out !== 32'd12 || valid_out !== 1'b1 || dest_out !== 4'd3) begin
            tests_failed++;
            $display("FAIL add_result got res=%0d vld=%b dst=%0d exp 12 1 3", alu_res_out, valid_out, dest_out);
        end
    endtask

    task automatic test_sub_flags();
        drive_idle();
        valid_in = 1'b1; exe_cmd_in = 4'b0100; val_rn_in = 32'd3; val_rm_in = 32'd3;
        status_w_en_in = 1'b1;
        #1;
        tests_run++;
        if (status_out !== 4'b0110 || status_w_en_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_flags got nzcv=%b wen=%b exp 0110 1", status_out, status_w_en_out);
        end
        tick();
    endtask

    task automatic test_forwarding();
        logic [1:0] s1, s2;
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            s1 = 2'(i); s2 = 2'(3 - i);
            valid_in = 1'b1; exe_cmd_in = 4'b0010;
            val_rn_in = (i == 1) ? 32'd9 : 32'd40; val_rm_in = 32'd1;
            mem_wb_value = 32'd100; wb_wb_value = 32'd1000;
            fwd_sel_src1 = s1; fwd_sel_src2 = s2;
            exp = m_fwd(s1, val_rn_in, 32'd100, 32'd1000) + m_fwd(s2, 32'd1, 32'd100, 32'd1000);
            tick();
            tests_run++;
            if (alu_res_out !== exp) begin
                tests_failed++;
                $display("FAIL fwd_%0d got %0d exp %0d", i, alu_res_out, exp);
            end
        end
    endtask

    task automatic test_alu_random(input int n);
        logic [31:0] a, b, op2, exp_res, exp_ba;
        logic [3:0]  exp_flags;
        int off;
        for (int i = 0; i < n; i++) begin
            drive_idle();
            exe_cmd_in = 4'($urandom_range(0, 15));
            if (exe_cmd_in == 4'b1010) exe_cmd_in = 4'b0011;
            valid_in = ($urandom_range(0, 7) != 0);
            immd_in = 1'($urandom_range(0, 1));
            mem_r_en_in = ($urandom_range(0, 5) == 0);
            mem_w_en_in = ($urandom_range(0, 5) == 0);
            wb_en_in = 1'($urandom_range(0, 1));
            status_w_en_in = 1'($urandom_range(0, 1));
            branch_taken_in = 1'($urandom_range(0, 1));
            val_rn_in = $urandom(); val_rm_in = $urandom();
            mem_wb_value = $urandom(); wb_wb_value = $urandom();
            fwd_sel_src1 = 2'($urandom_range(0, 3)); fwd_sel_src2 = 2'($urandom_range(0, 3));
            shift_operand_in = 12'($urandom()); status_reg_in = 4'($urandom());
            dest_in = 4'($urandom()); pc_in = $urandom(); signed_immd_24_in = 24'($urandom());
            a = m_fwd(fwd_sel_src1, val_rn_in, mem_wb_value, wb_wb_value);
            b = m_fwd(fwd_sel_src2, val_rm_in, mem_wb_value, wb_wb_value);
            op2 = m_op2(immd_in, mem_r_en_in | mem_w_en_in, shift_operand_in, b);
            m_alu(exe_cmd_in, a, op2, status_reg_in, exp_res, exp_flags);
            off = (signed_immd_24_in >= 24'h800000) ? int'(signed_immd_24_in) - (1 << 24)
                                                   : int'(signed_immd_24_in);
            exp_ba = pc_in + 32'(off * 4);
            #1;
            tests_run++;
            if (status_out !== exp_flags || stall_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL rnd_flags i=%0d cmd=%h got %b/%b exp %b/0", i, exe_cmd_in, status_out, stall_out, exp_flags);
            end
            tests_run++;
            if (branch_address_out !== exp_ba) begin
                tests_failed++;
                $display("FAIL rnd_baddr i=%0d got %h exp %h", i, branch_address_out, exp_ba);
            end
            tests_run++;
            if (status_w_en_out !== (status_w_en_in & valid_in) ||
                branch_taken_out !== (branch_taken_in & valid_in)) begin
                tests_failed++;
                $display("FAIL rnd_commit i=%0d got %b%b exp %b%b", i, status_w_en_out, branch_taken_out,
                         status_w_en_in & valid_in, branch_taken_in & valid_in);
            end
            tick();
            tests_run++;
            if (valid_out !== valid_in || wb_en_out !== (wb_en_in & valid_in)) begin
                tests_failed++;
                $display("FAIL rnd_valid i=%0d got %b%b exp %b%b", i, valid_out, wb_en_out, valid_in, wb_en_in & valid_in);
            end
            if (valid_in) begin
                tests_run++;
                if (alu_res_out !== exp_res || val_rm_out !== b || dest_out !== dest_in) begin
                    tests_failed++;
                    $display("FAIL rnd_result i=%0d cmd=%h got %h %h %h exp %h %h %h", i, exe_cmd_in,
                             alu_res_out, val_rm_out, dest_out, exp_res, b, dest_in);
                end
            end
        end
    endtask

    // MUL issued in cycle 1; optional freeze window and flush cycle.
    task automatic test_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                            input int frz_at, input int frz_len, input int flush_at);
        logic [31:0] p;
        int done;
        logic flushed, exp_stall;
        p = a * b;
        done = (flush_at > 0) ? 0 : 5 + frz_len;
        drive_idle();
        valid_in = 1'b1; exe_cmd_in = 4'b1010; val_rn_in = a; val_rm_in = b;
        status_w_en_in = 1'b1; status_reg_in = 4'b0011; wb_en_in = 1'b1; dest_in = 4'd9;
        for (int c = 1; c <= 11; c++) begin
            freeze_in = (c >= frz_at && c < frz_at + frz_len);
            flush_in  = (c == flush_at);
            flushed   = (flush_at > 0 && c > flush_at);
            if (flushed || (done > 0 && c > done)) valid_in = 1'b0;
            if (c >= 2) begin
                fwd_sel_src1 = 2'b01;
                mem_wb_value = $urandom();
            end
            #1;
            if (c != flush_at) begin
                exp_stall = freeze_in | (!flushed && c < done) | (flush_at > 0 && !flushed);
                tests_run++;
                if (stall_out !== exp_stall) begin
                    tests_failed++;
                    $display("FAIL %s_stall c=%0d got %b exp %b", name, c, stall_out, exp_stall);
                end
            end
            tests_run++;
            if (status_w_en_out !== (c == done)) begin
                tests_failed++;
                $display("FAIL %s_commit c=%0d got %b exp %b", name, c, status_w_en_out, c == done);
            end
            if (c == done) begin
                tests_run++;
                if (status_out !== {p[31], p == 32'd0, 2'b11}) begin
                    tests_failed++;
                    $display("FAIL %s_flags got %b exp %b", name, status_out, {p[31], p == 32'd0, 2'b11});
                end
            end
            tick();
            tests_run++;
            if (valid_out !== (c == done)) begin
                tests_failed++;
                $display("FAIL %s_valid c=%0d got %b exp %b", name, c, valid_out, c == done);
            end
            if (c == done) begin
                tests_run++;
                if (alu_res_out !== p || dest_out !== 4'd9 || wb_en_out !== 1'b1 || val_rm_out !== b) begin
                    tests_failed++;
                    $display("FAIL %s_result got %0d dst=%0d exp %0d dst=9", name, alu_res_out, dest_out, p);
                end
            end
        end
    endtask

    task automatic test_freeze_flush_idle();
        drive_idle();
        valid_in = 1'b1; exe_cmd_in = 4'b0010; val_rn_in = 32'd5; val_rm_in = 32'd7;
        tick();
        val_rn_in = 32'd20; val_rm_in = 32'd1; freeze_in = 1'b1;
        status_w_en_in = 1'b1; branch_taken_in = 1'b1;
        #1;
        tests_run++;
        if (stall_out !== 1'b1 || status_w_en_out !== 1'b0 || branch_taken_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL freeze_comb got stall=%b wen=%b bt=%b exp 1 0 0", stall_out, status_w_en_out, branch_taken_out);
        end
        tick();
        tests_run++;
        if (alu_res_out !== 32'd12 || valid_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL freeze_hold got %0d vld=%b exp 12 1", alu_res_out, valid_out);
        end
        flush_in = 1'b1;
        #1;
        tests_run++;
        if (branch_taken_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_commit got %b exp 0", branch_taken_out);
        end
        tick();
        tests_run++;
        if (valid_out !== 1'b0 || wb_en_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_bubble got %b%b exp 00", valid_out, wb_en_out);
        end
        flush_in = 1'b0; freeze_in = 1'b0;
        tick();
        tests_run++;
        if (alu_res_out !== 32'd21 || valid_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_flush got %0d vld=%b exp 21 1", alu_res_out, valid_out);
        end
    endtask

    task automatic test_branch();
        drive_idle();
        valid_in = 1'b1; exe_cmd_in = 4'b0001; branch_taken_in = 1'b1;
        pc_in = 32'h100; signed_immd_24_in = 24'hFFFFFE;
        #1;
        tests_run++;
        if (branch_address_out !== 32'hF8 || branch_taken_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_back got %h bt=%b exp 000000f8 1", branch_address_out, branch_taken_out);
        end
        pc_in = 32'hFFFF_FFFC; signed_immd_24_in = 24'h000001;
        #1;
        tests_run++;
        if (branch_address_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL branch_wrap got %h exp 00000000", branch_address_out);
        end
        tick();
    endtask

    task automatic test_rst_mid_mul();
        drive_idle();
        valid_in = 1'b1; exe_cmd_in = 4'b1010; val_rn_in = $urandom(); val_rm_in = $urandom();
        wb_en_in = 1'b1; dest_in = 4'hF;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; valid_in = 1'b0;
        #1;
        tests_run++;
        if ({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, stall_out} !== 5'b0 ||
            {alu_res_out, val_rm_out, dest_out} !== 68'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_mul got vld=%b stall=%b res=%h dst=%h exp zeros", valid_out, stall_out, alu_res_out, dest_out);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            tests_run++;
            if (valid_out !== 1'b0 || stall_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_no_late c=%0d got vld=%b stall=%b exp 0 0", c, valid_out, stall_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_sub_flags();
        test_forwarding();
        test_mul("mul_fixed", 32'd1234, 32'd5678, 0, 0, 0);
        test_mul("mul_rand", $urandom(), $urandom(), 0, 0, 0);
        test_mul("mul_freeze", 32'd1234, 32'd5678, 2, 3, 0);
        test_mul("mul_flush", 32'd1234, 32'd5678, 0, 0, 2);
        test_freeze_flush_idle();
        test_branch();
        test_alu_random(60);
        test_mul("mul_rand2", $urandom(), $urandom(), 3, 2, 0);
        test_rst_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
Parametrised execute stage with its EX/MEM pipeline register, the next generation of the single-cycle EX block. Adds generic data/address widths, a valid bit, downstream freeze, flush, and an iterative multi-cycle multiplier that stalls upstream stages. Sits between the ID/EX register and the MEM stage, and feeds the hazard unit, the status register and the fetch-stage branch logic.

Parameters:
DATA_W, 32, register and ALU width (multiple of MUL_BITS_PER_CYCLE, at least 16)
ADDR_W, 32, PC and branch address width
REG_ADDR_W, 4, register index width
MUL_BITS_PER_CYCLE, 8, multiplier bits retired per iteration; N_ITER = DATA_W/MUL_BITS_PER_CYCLE

Ports:
clk  in  1  clock
rst  in  1  reset
freeze_in  in  1  downstream hold request
flush_in  in  1  kill the instruction in EX
valid_in  in  1  ID/EX holds a real instruction
pc_in  in  ADDR_W  PC+4 of the instruction
wb_en_in, mem_r_en_in, mem_w_en_in, status_w_en_in, branch_taken_in, immd_in  in  1 each  decoded controls
exe_cmd_in  in  4  ALU command
val_rn_in, val_rm_in  in  DATA_W  register operands
dest_in  in  REG_ADDR_W  destination register
signed_immd_24_in  in  24  branch offset
shift_operand_in  in  12  operand-2 field
status_reg_in  in  4  current NZCV
fwd_sel_src1, fwd_sel_src2  in  2 each  00 register, 01 mem_wb_value, 10 wb_wb_value, 11 register
mem_wb_value, wb_wb_value  in  DATA_W  forwarded results
stall_out  out  1  upstream must hold
wb_en_hazard_out, dest_hazard_out  out  1 / REG_ADDR_W  copies of wb_en_in/dest_in for the hazard unit
status_w_en_out, status_out, branch_taken_out  out  1 / 4 / 1  combinational commit outputs
branch_address_out  out  ADDR_W  pc_in + (sign-extended imm24 << 2)
valid_out, wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered
alu_res_out, val_rm_out, dest_out  out  DATA_W / DATA_W / REG_ADDR_W  registered

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- On reset, every registered output is 0 and the FSM is IDLE.
- Priority order: rst, then flush_in, then freeze_in.
- Operand 2, normal ALU ops: immd_in=1 gives imm8 rotated right by 2*rotate. Otherwise forwarded Rm is shifted by shift_imm using LSL/LSR/ASR/ROR. For mem ops, operand 2 is the zero-extended 12-bit offset.
- ALU commands: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR, 1010 MUL (product of forwarded Rn and forwarded Rm, low DATA_W bits). Other codes produce result 0.
- Flags: N and Z from the result. C and V from add/sub only; logical ops and MUL pass C and V from status_reg_in.
- FSM states:
  - IDLE: a single-cycle op completes in the same cycle. MUL with valid_in and no freeze/flush captures operands, asserts stall_out combinationally, writes a bubble (valid_out=0) and moves to BUSY with cnt=0.
  - BUSY: each non-frozen cycle adds the partial product and increments cnt. stall_out stays 1 while cnt<N_ITER-1. On cnt=N_ITER-1, stall_out=0, the result and controls load into EX/MEM, and the FSM returns to IDLE. MUL latency is N_ITER+1 cycles (5 at default).
- Forwarding values are sampled only at MUL capture.
- freeze_in: holds the EX/MEM register, cnt and state. stall_out=1. Commit outputs are 0.
- flush_in: loads a bubble (all control outputs and valid_out 0), aborts any multiply and returns to IDLE. Commit outputs are 0.
- Commit outputs (status_w_en_out, branch_taken_out) equal the inputs ANDed with valid and commit. They are 0 in the MUL capture cycle and pulse only in the completing cycle.
- val_rm_out is forwarded Rm (store data).
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Package ex_pkg holds the exe_cmd encodings, shift-type codes, forwarding-select codes and the FSM state enum.
- Sub-module ex_val2_gen: combinational operand-2 generator.
- The multiplier iteration stays inline.

Test Plan:
- ADD, Rn=5, Rm=7, no forwarding -> next cycle alu_res_out=12, valid_out=1, stall_out never asserted.
- SUB, Rn=3, Rm=3, status_w_en=1 -> status_out=0110 (Z=1, C=1) in the same cycle.
- Forwarding: fwd_sel_src1=01, mem_wb_value=100, Rm=1, ADD -> alu_res_out=101.
- MUL 1234×5678 -> stall_out high for 4 cycles, result 7006652 registered at cycle 5, bubbles before that.
- MUL with freeze_in in cycle 2 for 3 cycles -> cnt holds and the result arrives 3 cycles late. Repeat with flush_in in cycle 2 -> bubble, IDLE, no result.
- Branch with pc_in=0x100, imm24=0xFFFFFE -> branch_address_out=0xF8. Also assert rst mid-MUL -> all outputs 0 the next cycle.
